cakegame_play_input: RTL and testbench

- Player-side responder for the cakegame control unit's wait_play/has_play/timeout interface.
- Synchronises and debounces the raw play buttons, then validates single-button press-release gestures.
- On each valid gesture, emits a one-cycle has_play pulse with the captured play.
- Generates the timeout level from the control unit's enable_timeout_counter (arm) so the UC can leave wait_play.

---
 rtl/cakegame_play_input.sv | 169 ++++++++++++++++
 tb/tb_cakegame_play_input.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cakegame_play_input.sv
// Player-side responder for the cakegame control unit: synchronises and debounces the
// play buttons, validates single-button press/release gestures and generates the play timeout.
module cakegame_play_input #(
  parameter int unsigned NUM_BUTTONS     = 4,
  parameter int unsigned CODE_W          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned TIMEOUT_CYCLES  = 250000000,
  parameter int unsigned CNT_W           = 28
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [NUM_BUTTONS-1:0] i_buttons,
  input  logic                   i_arm,
  output logic                   o_has_play,
  output logic [NUM_BUTTONS-1:0] o_play_onehot,
  output logic [CODE_W-1:0]      o_play_code,
  output logic                   o_reject,
  output logic                   o_timeout,
  output logic [1:0]             o_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READY   = 2'd1,
    PRESSED = 2'd2,
    REPORT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT_CYCLES);

  function automatic logic f_multi_hot(input logic [NUM_BUTTONS-1:0] v);
    return |(v & (v - NUM_BUTTONS'(1)));
  endfunction

  function automatic logic [CODE_W-1:0] f_encode(input logic [NUM_BUTTONS-1:0] v);
    logic [CODE_W-1:0] code;
    code = '0;
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      if (v[i]) code = code | CODE_W'(i);
    end
    return code;
  endfunction

  state_t                 r_state, w_state_nxt;
  logic [NUM_BUTTONS-1:0] r_sync1, r_sync2, r_sync_prev, r_deb;
  logic [CNT_W-1:0]       r_stable_cnt, r_to_cnt, w_to_cnt_d;
  logic [NUM_BUTTONS-1:0] r_cap, w_cap_d, r_onehot, w_onehot_d;
  logic [CODE_W-1:0]      r_code, w_code_d;
  logic                   r_multi, w_multi_d;
  logic                   r_has_play, w_has_play_d, r_reject, w_reject_d;
  logic                   r_timeout, w_timeout_d;
  logic                   w_sync_stable, w_quiet, w_deb_any;

  assign w_sync_stable = (r_sync2 == r_sync_prev);
  assign w_deb_any     = (r_deb != '0);
  // Fully settled release: nothing pressed anywhere along the synchroniser/debouncer path.
  assign w_quiet = !w_deb_any && (r_sync1 == '0) && (r_sync2 == '0) && w_sync_stable &&
                   (r_stable_cnt == DEB_MAX);

  // Two-flop synchroniser and whole-vector debouncer.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_sync_prev  <= '0;
      r_deb        <= '0;
      r_stable_cnt <= '0;
    end else begin
      r_sync1     <= i_buttons;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
      if (!w_sync_stable) begin
        r_stable_cnt <= '0;
      end else if (r_stable_cnt != DEB_MAX) begin
        r_stable_cnt <= r_stable_cnt + CNT_W'(1);
      end
      if (w_sync_stable && (r_stable_cnt == DEB_MAX)) r_deb <= r_sync2;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_quiet) w_state_nxt = READY;
      READY:   if (i_arm && w_deb_any) w_state_nxt = PRESSED;
      PRESSED: begin
        if (!i_arm)          w_state_nxt = IDLE;
        else if (!w_deb_any) w_state_nxt = REPORT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Gesture capture, report pulses and timeout counter; the pulses land during REPORT.
  always_comb begin
    w_cap_d      = r_cap;
    w_multi_d    = r_multi;
    w_onehot_d   = r_onehot;
    w_code_d     = r_code;
    w_has_play_d = 1'b0;
    w_reject_d   = 1'b0;
    w_to_cnt_d   = r_to_cnt;
    case (r_state)
      READY: begin
        if (i_arm && w_deb_any) begin
          w_cap_d   = r_deb;
          w_multi_d = f_multi_hot(r_deb);
        end
      end
      PRESSED: begin
        if (i_arm && w_deb_any) begin
          w_cap_d   = r_cap | r_deb;
          w_multi_d = r_multi | f_multi_hot(r_cap | r_deb);
        end else if (i_arm) begin
          if (r_multi) begin
            w_reject_d = 1'b1;
          end else begin
            w_has_play_d = 1'b1;
            w_onehot_d   = r_cap;
            w_code_d     = f_encode(r_cap);
          end
        end
      end
      default: ;
    endcase
    if (!i_arm || r_has_play) begin
      w_to_cnt_d = '0;
    end else if ((r_state != PRESSED) && (r_to_cnt != TO_MAX)) begin
      w_to_cnt_d = r_to_cnt + CNT_W'(1);
    end
    w_timeout_d = i_arm && (w_to_cnt_d == TO_MAX) && !w_has_play_d;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cap      <= '0;
      r_multi    <= 1'b0;
      r_onehot   <= '0;
      r_code     <= '0;
      r_has_play <= 1'b0;
      r_reject   <= 1'b0;
      r_to_cnt   <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_cap      <= w_cap_d;
      r_multi    <= w_multi_d;
      r_onehot   <= w_onehot_d;
      r_code     <= w_code_d;
      r_has_play <= w_has_play_d;
      r_reject   <= w_reject_d;
      r_to_cnt   <= w_to_cnt_d;
      r_timeout  <= w_timeout_d;
    end
  end

  assign o_has_play    = r_has_play;
  assign o_play_onehot = r_onehot;
  assign o_play_code   = r_code;
  assign o_reject      = r_reject;
  assign o_timeout     = r_timeout;
  assign o_state       = r_state;

endmodule

// File: tb/tb_cakegame_play_input.sv
// Directed self-checking bench for cakegame_play_input with short debounce/timeout settings.
module tb_cakegame_play_input;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] buttons;
  logic       arm;
  logic       has_play;
  logic [3:0] play_onehot;
  logic [1:0] play_code;
  logic       reject;
  logic       timeout;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int hp_cnt = 0;
  int rj_cnt = 0;

  cakegame_play_input #(
    .NUM_BUTTONS(4), .CODE_W(2), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(20), .CNT_W(28)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_buttons(buttons), .i_arm(arm),
    .o_has_play(has_play), .o_play_onehot(play_onehot), .o_play_code(play_code),
    .o_reject(reject), .o_timeout(timeout), .o_state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (has_play) hp_cnt++;
    if (reject)   rj_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    int hp0, rj0, first, seen_to, bad_state;

    // Reset with a button held: everything clear, and no gesture until a release.
    rst = 1'b1; arm = 1'b0; buttons = 4'b0010;
    repeat (3) tick();
    chk("rst_has_play", 32'(has_play), 0);
    chk("rst_onehot", 32'(play_onehot), 0);
    chk("rst_code", 32'(play_code), 0);
    chk("rst_reject", 32'(reject), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_state", 32'(state), 0);
    rst = 1'b0;
    repeat (15) tick();
    chk("held_after_rst_state", 32'(state), 0);
    chk("held_after_rst_hp", 32'(hp_cnt), 0);
    buttons = 4'b0000;
    repeat (15) tick();
    chk("released_state_ready", 32'(state), 1);

    // Clean single press of button 2.
    hp0 = hp_cnt; first = 0; seen_to = 0;
    arm = 1'b1; buttons = 4'b0100;
    repeat (10) tick();
    buttons = 4'b0000;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (has_play && first == 0) first = i;
      if (timeout) seen_to = 1;
    end
    chk("clean_latency", 32'(first), 8);
    chk("clean_onehot", 32'(play_onehot), 32'h4);
    chk("clean_code", 32'(play_code), 2);
    repeat (5) tick();
    chk("clean_one_pulse", 32'(hp_cnt - hp0), 1);
    chk("clean_onehot_held", 32'(play_onehot), 32'h4);
    chk("clean_no_timeout", 32'(seen_to), 0);
    arm = 1'b0;
    repeat (2) tick();

    // Bouncing bit0 with 2-cycle runs never passes the debouncer.
    hp0 = hp_cnt; rj0 = rj_cnt; bad_state = 0;
    arm = 1'b1;
    for (int i = 0; i < 12; i++) begin
      buttons = (((i / 2) % 2) == 0) ? 4'b0001 : 4'b0000;
      tick();
      if (state != 2'd1) bad_state = 1;
    end
    buttons = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (state != 2'd1) bad_state = 1;
    end
    chk("bounce_state_ready", 32'(bad_state), 0);
    chk("bounce_no_play", 32'(hp_cnt - hp0), 0);
    chk("bounce_no_reject", 32'(rj_cnt - rj0), 0);
    arm = 1'b0;
    repeat (2) tick();

    // Two buttons in one gesture: rejected, previous play kept.
    hp0 = hp_cnt; rj0 = rj_cnt;
    arm = 1'b1; buttons = 4'b0001;
    repeat (8) tick();
    buttons = 4'b1001;
    repeat (8) tick();
    buttons = 4'b0000;
    repeat (12) tick();
    chk("multi_reject_once", 32'(rj_cnt - rj0), 1);
    chk("multi_no_play", 32'(hp_cnt - hp0), 0);
    chk("multi_onehot_kept", 32'(play_onehot), 32'h4);
    chk("multi_code_kept", 32'(play_code), 2);
    arm = 1'b0;
    repeat (2) tick();

    // Idle timeout exactly 20 cycles after arm rises; drops one cycle after arm falls.
    seen_to = 0;
    arm = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      tick();
      if (timeout) seen_to = 1;
    end
    chk("timeout_not_early", 32'(seen_to), 0);
    tick();
    chk("timeout_at_20", 32'(timeout), 1);
    repeat (3) tick();
    chk("timeout_held", 32'(timeout), 1);
    arm = 1'b0;
    tick();
    chk("timeout_cleared", 32'(timeout), 0);
    repeat (2) tick();

    // Press late in the window: the counter freezes while pressed, so the play wins.
    hp0 = hp_cnt; seen_to = 0; first = 0;
    arm = 1'b1;
    for (int i = 0; i < 8; i++) begin tick(); if (timeout) seen_to = 1; end
    buttons = 4'b0001;
    for (int i = 0; i < 10; i++) begin tick(); if (timeout) seen_to = 1; end
    buttons = 4'b0000;
    for (int i = 1; i <= 20 && first == 0; i++) begin
      tick();
      if (has_play) first = i;
      else if (timeout) seen_to = 1;
    end
    chk("freeze_no_timeout", 32'(seen_to), 0);
    chk("freeze_play_seen", 32'(first != 0), 1);
    chk("freeze_onehot", 32'(play_onehot), 32'h1);
    chk("freeze_code", 32'(play_code), 0);
    arm = 1'b0;
    repeat (3) tick();

    // Arm drop during a press aborts the gesture.
    hp0 = hp_cnt; rj0 = rj_cnt;
    arm = 1'b1; buttons = 4'b1000;
    repeat (10) tick();
    chk("abort_in_pressed", 32'(state), 2);
    arm = 1'b0;
    repeat (2) tick();
    chk("abort_idle", 32'(state), 0);
    buttons = 4'b0000;
    repeat (15) tick();
    chk("abort_ready", 32'(state), 1);
    chk("abort_no_play", 32'(hp_cnt - hp0), 0);
    chk("abort_no_reject", 32'(rj_cnt - rj0), 0);
    chk("abort_onehot_kept", 32'(play_onehot), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
